// File: rtl/note_pkg.sv
// Shared widths, pitch table, length saturation and state encoding for the
// note_player block and its tone_divider.
package note_pkg;

  localparam int OCTAVE_BITS = 2;
  localparam int NOTE_BITS   = 3;
  localparam int LENGTH_BITS = 3;
  localparam int HALF_BITS   = 18;
  localparam int DUR_BITS    = 31;

  localparam logic [NOTE_BITS-1:0]   NOTE_REST  = 3'd7;
  localparam logic [LENGTH_BITS-1:0] LENGTH_MAX = 3'd6;

  // Octave-0 half periods at 100 MHz for C..B; index 7 (rest) never drives the divider.
  localparam logic [HALF_BITS-1:0] HALF_PERIOD [8] = '{
    18'd191113, 18'd170262, 18'd151686, 18'd143172,
    18'd127551, 18'd113636, 18'd101239, 18'd0
  };

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  function automatic logic [HALF_BITS-1:0] half_period_of(
    input logic [NOTE_BITS-1:0]   n,
    input logic [OCTAVE_BITS-1:0] o
  );
    return HALF_PERIOD[n] >> o;
  endfunction

  function automatic logic [LENGTH_BITS-1:0] sat_length(input logic [LENGTH_BITS-1:0] len);
    return (len > LENGTH_MAX) ? LENGTH_MAX : len;
  endfunction

endpackage

// File: rtl/note_player_tone_divider.sv
// Square-wave generator: high for half_period cycles, low for half_period
// cycles, repeating while run; forced low and rearmed when run drops.
module tone_divider
  import note_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [HALF_BITS-1:0] half_period,
  output logic                 buzzer
);

  logic [HALF_BITS-1:0] cnt_q, cnt_d;
  logic                 phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (run) begin
      if (cnt_q == half_period - HALF_BITS'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + HALF_BITS'(1);
        phase_d = phase_q;
      end
    end
  end

  // Gating with run makes the first tone cycle high without waiting a clock.
  assign buzzer = run & ~phase_q;

endmodule

// File: rtl/note_player.sv
// Plays one (octave, note, length) event on the buzzer, then a silent gap,
// then pulses done. Optional one-entry queue: define NOTE_PLAYER_QUEUE_EN.
module note_player
  import note_pkg::*;
#(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [OCTAVE_BITS-1:0] octave,
  input  logic [NOTE_BITS-1:0]   note,
  input  logic [LENGTH_BITS-1:0] length,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
`ifdef NOTE_PLAYER_QUEUE_EN
  output logic                   queue_full,
`endif
  output logic                   buzzer
);

  localparam logic [DUR_BITS-1:0] GAP_LOAD = DUR_BITS'(GAP_CYCLES - 1);

  function automatic logic [DUR_BITS-1:0] tone_load(input logic [LENGTH_BITS-1:0] len);
    return (DUR_BITS'(UNIT_CYCLES) << len) - DUR_BITS'(1);
  endfunction

  state_t                 state_q, state_d;
  logic [DUR_BITS-1:0]    dur_q, dur_d;
  logic                   done_q, done_d;
  logic [OCTAVE_BITS-1:0] oct_q, oct_d;
  logic [NOTE_BITS-1:0]   note_q, note_d;
  logic [LENGTH_BITS-1:0] len_q, len_d;
  logic                   run;

`ifdef NOTE_PLAYER_QUEUE_EN
  logic                   qv_q, qv_d;
  logic [OCTAVE_BITS-1:0] qoct_q, qoct_d;
  logic [NOTE_BITS-1:0]   qnote_q, qnote_d;
  logic [LENGTH_BITS-1:0] qlen_q, qlen_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      done_q  <= 1'b0;
`ifdef NOTE_PLAYER_QUEUE_EN
      qv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      done_q  <= done_d;
`ifdef NOTE_PLAYER_QUEUE_EN
      qv_q    <= qv_d;
`endif
    end
  end

  // Event payload registers need no reset: they are only read once loaded.
  always_ff @(posedge clk) begin
    oct_q  <= oct_d;
    note_q <= note_d;
    len_q  <= len_d;
`ifdef NOTE_PLAYER_QUEUE_EN
    qoct_q  <= qoct_d;
    qnote_q <= qnote_d;
    qlen_q  <= qlen_d;
`endif
  end

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    done_d  = 1'b0;
    oct_d   = oct_q;
    note_d  = note_q;
    len_d   = len_q;
`ifdef NOTE_PLAYER_QUEUE_EN
    qv_d    = qv_q;
    qoct_d  = qoct_q;
    qnote_d = qnote_q;
    qlen_d  = qlen_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef NOTE_PLAYER_QUEUE_EN
        // A pending queued event takes priority over a new start.
        if (abort) begin
          qv_d = 1'b0;
        end else if (qv_q) begin
          state_d = TONE;
          oct_d   = qoct_q;
          note_d  = qnote_q;
          len_d   = qlen_q;
          dur_d   = tone_load(qlen_q);
          qv_d    = 1'b0;
        end else
`endif
        if (start && !abort) begin
          state_d = TONE;
          oct_d   = octave;
          note_d  = note;
          len_d   = sat_length(length);
          dur_d   = tone_load(sat_length(length));
        end
      end
      TONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dur_q == '0) begin
          state_d = GAP;
          dur_d   = GAP_LOAD;
        end else begin
          dur_d = dur_q - DUR_BITS'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dur_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          dur_d = dur_q - DUR_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef NOTE_PLAYER_QUEUE_EN
    if (state_q != IDLE) begin
      if (abort) begin
        qv_d = 1'b0;
      end else if (start && !qv_q) begin
        qv_d    = 1'b1;
        qoct_d  = octave;
        qnote_d = note;
        qlen_d  = sat_length(length);
      end
    end
`endif
  end

  always_comb begin
`ifdef NOTE_PLAYER_QUEUE_EN
    busy       = (state_q != IDLE) || qv_q;
    queue_full = qv_q;
`else
    busy = (state_q != IDLE);
`endif
    done = done_q;
    run  = (state_q == TONE) && (note_q != NOTE_REST);
  end

  tone_divider u_div (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .half_period (half_period_of(note_q, oct_q)),
    .buzzer      (buzzer)
  );

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with UNIT_CYCLES=500, GAP_CYCLES=4.
module tb_note_player;

  localparam int UNIT = 500;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] octave = '0;
  logic [2:0] note = '0;
  logic [2:0] length = '0;
  logic       abort = 1'b0;
  logic       busy, done, buzzer;
`ifdef NOTE_PLAYER_QUEUE_EN
  logic       queue_full;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  note_player #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .octave (octave),
    .note   (note),
    .length (length),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
`ifdef NOTE_PLAYER_QUEUE_EN
    .queue_full (queue_full),
`endif
    .buzzer (buzzer)
  );

  typedef struct {
    logic [1:0] oct;
    logic [2:0] nt;
    logic [2:0] len;
    int         lat;       // offset of the done pulse; offset 1 = first TONE cycle
    int         first_tog; // divider cycles before first toggle, 0 = none
    int         toggles;
    logic       first_buz;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns with the sample at offset 1.
  task automatic start_evt(input logic [1:0] o, input logic [2:0] n, input logic [2:0] l);
    @(negedge clk);
    octave = o; note = n; length = l; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   off, tog, ft, tone_end, done_off;
    logic prev, busy_at_done;
    bit   busy_ok, gap_ok;
    tone_end = v.lat - 1 - GAP;
    start_evt(v.oct, v.nt, v.len);
    off = 1;
    chk($sformatf("v%0d_busy_rise", idx), busy, 1);
    chk($sformatf("v%0d_first_buzzer", idx), buzzer, v.first_buz);
    prev = buzzer; tog = 0; ft = 0; busy_ok = 1; gap_ok = 1; done_off = 0; busy_at_done = 1'b1;
    while (done_off == 0 && off < v.lat + 20) begin
      tick();
      off++;
      if (done) begin
        done_off = off;
        busy_at_done = busy;
      end else if (!busy) begin
        busy_ok = 0;
      end
      if (off <= tone_end && buzzer !== prev) begin
        tog++;
        if (ft == 0) ft = off - 1;
      end
      if (off > tone_end && buzzer !== 1'b0) gap_ok = 0;
      prev = buzzer;
    end
    chk($sformatf("v%0d_done_offset", idx), done_off, v.lat);
    chk($sformatf("v%0d_busy_at_done", idx), busy_at_done, 0);
    chk($sformatf("v%0d_busy_held", idx), busy_ok, 1);
    chk($sformatf("v%0d_toggles", idx), tog, v.toggles);
    chk($sformatf("v%0d_first_toggle", idx), ft, v.first_tog);
    chk($sformatf("v%0d_gap_silent", idx), gap_ok, 1);
    tick();
    chk($sformatf("v%0d_done_single", idx), done, 0);
  endtask

  initial begin
    int dones, d1, d2;
    bit busy_seen;

    // A oct3: H=14204; G oct3: H=15943; E oct2: H=37921; C oct0: H=191113.
    vecs[0] = '{oct: 2'd3, nt: 3'd5, len: 3'd7, lat: 1 + (UNIT << 6) + GAP, first_tog: 14204, toggles: 2, first_buz: 1'b1};
    vecs[1] = '{oct: 2'd0, nt: 3'd7, len: 3'd1, lat: 1 + (UNIT << 1) + GAP, first_tog: 0,     toggles: 0, first_buz: 1'b0};
    vecs[2] = '{oct: 2'd3, nt: 3'd4, len: 3'd5, lat: 1 + (UNIT << 5) + GAP, first_tog: 15943, toggles: 1, first_buz: 1'b1};
    vecs[3] = '{oct: 2'd0, nt: 3'd0, len: 3'd0, lat: 1 + UNIT + GAP,        first_tog: 0,     toggles: 0, first_buz: 1'b1};
    vecs[4] = '{oct: 2'd2, nt: 3'd2, len: 3'd3, lat: 1 + (UNIT << 3) + GAP, first_tog: 0,     toggles: 0, first_buz: 1'b1};

    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_buzzer", buzzer, 0);
`ifdef NOTE_PLAYER_QUEUE_EN
    chk("reset_queue_full", queue_full, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Reset during TONE discards the event.
    start_evt(2'd0, 3'd0, 3'd3);
    repeat (499) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_buzzer", buzzer, 0);
    dones = 0;
    repeat (4500) begin tick(); if (done) dones++; end
    chk("rst_mid_no_done", dones, 0);

    // Abort during TONE.
    start_evt(2'd0, 3'd0, 3'd3);
    repeat (499) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_tone_busy", busy, 0);
    chk("abort_tone_buzzer", buzzer, 0);
    dones = 0;
    repeat (4500) begin tick(); if (done) dones++; end
    chk("abort_tone_no_done", dones, 0);

    // Abort during GAP (offsets 501..504 for length 0).
    start_evt(2'd0, 3'd0, 3'd0);
    repeat (501) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_gap_busy", busy, 0);
    dones = 0;
    repeat (50) begin tick(); if (done) dones++; end
    chk("abort_gap_no_done", dones, 0);

    // Abort and start together in IDLE: start dropped.
    @(negedge clk);
    octave = 2'd3; note = 3'd5; length = 3'd0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    busy_seen = 0; dones = 0;
    repeat (600) begin tick(); if (busy) busy_seen = 1; if (done) dones++; end
    chk("abort_start_stays_idle", busy_seen, 0);
    chk("abort_start_no_done", dones, 0);

    // Second start while busy at offset 10.
    start_evt(2'd3, 3'd5, 3'd0);
    repeat (9) tick();
    octave = 2'd0; note = 3'd0;
`ifdef NOTE_PLAYER_QUEUE_EN
    length = 3'd0;
`else
    length = 3'd7;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0; d1 = 0; d2 = 0;
`ifdef NOTE_PLAYER_QUEUE_EN
    chk("queue_full_set", queue_full, 1);
`endif
    for (int off = 12; off <= 1500; off++) begin
      tick();
      if (done) begin
        dones++;
        if (dones == 1) d1 = off;
        if (dones == 2) d2 = off;
`ifdef NOTE_PLAYER_QUEUE_EN
        if (dones == 1) chk("queue_busy_at_done", busy, 1);
`endif
      end
`ifdef NOTE_PLAYER_QUEUE_EN
      if (off == 506) begin
        chk("queue_second_busy", busy, 1);
        chk("queue_full_clear", queue_full, 0);
      end
`endif
    end
    chk("busy_start_first_done", d1, 1 + UNIT + GAP);
`ifdef NOTE_PLAYER_QUEUE_EN
    chk("queue_done_count", dones, 2);
    chk("queue_second_done", d2, 2 * (1 + UNIT + GAP));
`else
    chk("busy_start_done_count", dones, 1);
    chk("busy_start_second_done", d2, 0);

    // Start in the last GAP cycle (offset 504) is ignored.
    start_evt(2'd0, 3'd0, 3'd0);
    repeat (503) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_at_done_pulse", done, 1);
    busy_seen = 0;
    repeat (50) begin tick(); if (busy) busy_seen = 1; end
    chk("start_at_done_ignored", busy_seen, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
